// File: rtl/dac_window_sequencer.sv
// dac_window_sequencer
// Closed-loop stim sequencer. Steps the DAC state counter once per
// amplifier sample while the evaluator keeps voting "advance". A full window
// of good samples fires a fixed-width stim pulse. The sequencer then waits out
// a refractory period counted in samples, and re-arms.
// Window and holdoff lengths are captured on IDLE->TRACK entry, so that
// register writes made mid-run cannot disturb a window already in progress.
module dac_window_sequencer #(
  parameter int CNT_W     = 32,
  parameter int PULSE_CYC = 4,
  parameter int TRIAL_W   = 16
) (
  input  logic               dataclk,
  input  logic               reset,
  input  logic               arm,
  input  logic               sample_tick,
  input  logic               DAC_advance,
  input  logic               DAC_any_enabled,
  input  logic [CNT_W-1:0]   window_len,
  input  logic [CNT_W-1:0]   holdoff_len,
  output logic [CNT_W-1:0]   DAC_fsm_state_counter,
  output logic               stim_trigger,
  output logic [1:0]         seq_state,
  output logic               reject,
  output logic [TRIAL_W-1:0] stim_count
);

  // Pulse-width counter only needs to reach PULSE_CYC-1.
  localparam int PLS_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

  localparam logic [PLS_W-1:0]   PLS_ZERO   = {PLS_W{1'b0}};
  localparam logic [PLS_W-1:0]   PLS_ONE    = {{(PLS_W-1){1'b0}}, 1'b1};
  localparam logic [PLS_W-1:0]   PLS_LAST   = PLS_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TRIAL_W-1:0] TRIAL_ONE  = {{(TRIAL_W-1){1'b0}}, 1'b1};
  localparam logic [TRIAL_W-1:0] TRIAL_MAX  = {TRIAL_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_STIM    = 2'd2,
    ST_HOLDOFF = 2'd3
  } seq_state_e;

  seq_state_e          state_r,    state_s;
  logic [CNT_W-1:0]    cnt_r,      cnt_s;
  logic [CNT_W-1:0]    win_r,      win_s;
  logic [CNT_W-1:0]    hold_r,     hold_s;
  logic [CNT_W-1:0]    hold_cnt_r, hold_cnt_s;
  logic [PLS_W-1:0]    pulse_cnt_r, pulse_cnt_s;
  logic                reject_r,   reject_s;
  logic                stim_trigger_r;
  logic                stim_entry_s;
  logic [TRIAL_W-1:0]  stim_count_r;

  // Next-state, counter and latch update logic for the sequencer.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    win_s        = win_r;
    hold_s       = hold_r;
    hold_cnt_s   = hold_cnt_r;
    pulse_cnt_s  = pulse_cnt_r;
    reject_s     = 1'b0;
    stim_entry_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        cnt_s = CNT_ZERO;
        if (arm && DAC_any_enabled) begin
          state_s = ST_TRACK;
          // A zero-length window behaves as a single-sample window.
          win_s   = (window_len == CNT_ZERO) ? CNT_ONE : window_len;
          hold_s  = holdoff_len;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_TRACK: begin
        // Abort takes priority over a coincident sample tick.
        if (!arm || !DAC_any_enabled) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end else if (sample_tick) begin
          if (!DAC_advance) begin
            cnt_s    = CNT_ZERO;
            reject_s = 1'b1;
          end else if (cnt_r == (win_r - CNT_ONE)) begin
            cnt_s        = CNT_ZERO;
            state_s      = ST_STIM;
            pulse_cnt_s  = PLS_ZERO;
            stim_entry_s = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end

      ST_STIM: begin
        // Pulse always runs to completion; only reset can cut it short.
        cnt_s = CNT_ZERO;
        if (pulse_cnt_r == PLS_LAST) begin
          if (!arm) begin
            state_s = ST_IDLE;
          end else if (hold_r == CNT_ZERO) begin
            state_s = ST_TRACK;
          end else begin
            state_s    = ST_HOLDOFF;
            hold_cnt_s = CNT_ZERO;
          end
        end else begin
          pulse_cnt_s = pulse_cnt_r + PLS_ONE;
        end
      end

      ST_HOLDOFF: begin
        cnt_s = CNT_ZERO;
        if (!arm) begin
          state_s = ST_IDLE;
        end else if (sample_tick) begin
          if (hold_cnt_r == (hold_r - CNT_ONE)) begin
            state_s = ST_TRACK;
          end else begin
            hold_cnt_s = hold_cnt_r + CNT_ONE;
          end
        end else begin
          hold_cnt_s = hold_cnt_r;
        end
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State register and datapath latches.
  always_ff @(posedge dataclk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      win_r       <= CNT_ZERO;
      hold_r      <= CNT_ZERO;
      hold_cnt_r  <= CNT_ZERO;
      pulse_cnt_r <= PLS_ZERO;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      win_r       <= win_s;
      hold_r      <= hold_s;
      hold_cnt_r  <= hold_cnt_s;
      pulse_cnt_r <= pulse_cnt_s;
    end
  end

  // Registered pulse outputs: stim high for every cycle spent in STIM, reject for one cycle.
  always_ff @(posedge dataclk or negedge reset) begin
    if (!reset) begin
      stim_trigger_r <= 1'b0;
      reject_r       <= 1'b0;
    end else begin
      stim_trigger_r <= (state_s == ST_STIM);
      reject_r       <= reject_s;
    end
  end

  // Saturating count of stims issued, bumped once on each STIM entry.
  always_ff @(posedge dataclk or negedge reset) begin
    if (!reset) begin
      stim_count_r <= {TRIAL_W{1'b0}};
    end else if (stim_entry_s && (stim_count_r != TRIAL_MAX)) begin
      stim_count_r <= stim_count_r + TRIAL_ONE;
    end else begin
      stim_count_r <= stim_count_r;
    end
  end

  assign DAC_fsm_state_counter = cnt_r;
  assign stim_trigger          = stim_trigger_r;
  assign seq_state             = state_r;
  assign reject                = reject_r;
  assign stim_count            = stim_count_r;

endmodule

// File: tb/tb_dac_window_sequencer.sv
// Self-checking bench for dac_window_sequencer.
// A behavioural model tracks mode, samples-into-window, pulse cycles left
// and holdoff ticks left. It is updated once per rising edge from the
// stimulus the bench drives, and every output is compared each cycle.
// The trial counter is narrowed so that saturation can be reached quickly.
module tb_dac_window_sequencer;

  localparam int CNT_W     = 32;
  localparam int PULSE_CYC = 4;
  localparam int TRIAL_W   = 4;
  localparam int SAT       = (1 << TRIAL_W) - 1;

  logic               dataclk = 1'b0;
  logic               rst_n;
  logic               arm;
  logic               sample_tick;
  logic               DAC_advance;
  logic               DAC_any_enabled;
  logic [CNT_W-1:0]   window_len;
  logic [CNT_W-1:0]   holdoff_len;
  logic [CNT_W-1:0]   DAC_fsm_state_counter;
  logic               stim_trigger;
  logic [1:0]         seq_state;
  logic               reject;
  logic [TRIAL_W-1:0] stim_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 idle, 1 tracking, 2 stimulating, 3 refractory.
  int m_mode, m_cnt, m_win, m_hold, m_pulse_left, m_hold_left, m_count;
  int m_reject, m_trig;

  dac_window_sequencer #(
    .CNT_W(CNT_W), .PULSE_CYC(PULSE_CYC), .TRIAL_W(TRIAL_W)
  ) dut (
    .dataclk              (dataclk),
    .reset                (rst_n),
    .arm                  (arm),
    .sample_tick          (sample_tick),
    .DAC_advance          (DAC_advance),
    .DAC_any_enabled      (DAC_any_enabled),
    .window_len           (window_len),
    .holdoff_len          (holdoff_len),
    .DAC_fsm_state_counter(DAC_fsm_state_counter),
    .stim_trigger         (stim_trigger),
    .seq_state            (seq_state),
    .reject               (reject),
    .stim_count           (stim_count)
  );

  always #5 dataclk = ~dataclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_win = 0; m_hold = 0;
    m_pulse_left = 0; m_hold_left = 0; m_count = 0;
    m_reject = 0; m_trig = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_step();
    m_reject = 0;
    case (m_mode)
      0: begin
        m_cnt = 0;
        if (arm && DAC_any_enabled) begin
          m_mode = 1;
          m_win  = (window_len == 0) ? 1 : int'(window_len);
          m_hold = int'(holdoff_len);
        end
      end
      1: begin
        if (!arm || !DAC_any_enabled) begin
          m_mode = 0; m_cnt = 0;
        end else if (sample_tick) begin
          if (!DAC_advance) begin
            m_cnt = 0; m_reject = 1;
          end else if (m_cnt + 1 == m_win) begin
            m_cnt = 0; m_mode = 2; m_pulse_left = PULSE_CYC;
            if (m_count < SAT) m_count++;
          end else begin
            m_cnt++;
          end
        end
      end
      2: begin
        m_pulse_left--;
        if (m_pulse_left == 0) begin
          if (!arm) m_mode = 0;
          else if (m_hold == 0) m_mode = 1;
          else begin m_mode = 3; m_hold_left = m_hold; end
        end
      end
      default: begin
        if (!arm) m_mode = 0;
        else if (sample_tick) begin
          m_hold_left--;
          if (m_hold_left == 0) m_mode = 1;
        end
      end
    endcase
    m_trig = (m_mode == 2) ? 1 : 0;
  endtask

  task automatic check_all();
    check_eq("counter", DAC_fsm_state_counter, 32'(m_cnt));
    check_eq("stim_trigger", 32'(stim_trigger), 32'(m_trig));
    check_eq("seq_state", 32'(seq_state), 32'(m_mode));
    check_eq("reject", 32'(reject), 32'(m_reject));
    check_eq("stim_count", 32'(stim_count), 32'(m_count));
  endtask

  // One clock cycle: drive inputs, take the edge, update model, compare.
  task automatic cycle(input logic a, input logic t, input logic d, input logic e);
    arm = a; sample_tick = t; DAC_advance = d; DAC_any_enabled = e;
    @(posedge dataclk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic to_idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; sample_tick = 1'b0; DAC_advance = 1'b0;
    DAC_any_enabled = 1'b0; window_len = '0; holdoff_len = '0;
    model_reset();
    #1;
    check_all();
    check_eq("reset_state", 32'(seq_state), 32'd0);
    #1 rst_n = 1'b1;

    // Window of 3 with holdoff of 2, ticks every other cycle.
    window_len = 32'd3; holdoff_len = 32'd2;
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      if (i == 2) check_eq("s1_stim_latency", 32'(stim_trigger), 32'd1);
      cycle(1'b1, 1'b0, 1'b1, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, 1'b1);
    end
    check_eq("s1_count", 32'(stim_count), 32'd1);
    check_eq("s1_back_to_track", 32'(seq_state), 32'd1);

    // Window of 4, advance drops on the third tick.
    to_idle();
    window_len = 32'd4;
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("s2_reject", 32'(reject), 32'd1);
    check_eq("s2_counter_cleared", DAC_fsm_state_counter, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("s2_stim", 32'(seq_state), 32'd2);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1);

    // Zero window, zero holdoff.
    to_idle();
    window_len = 32'd0; holdoff_len = 32'd0;
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("s3_first_tick_stim", 32'(stim_trigger), 32'd1);
    for (int i = 0; i < PULSE_CYC; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("s3_direct_track", 32'(seq_state), 32'd1);

    // Arm drops during the second STIM cycle: full pulse, then idle.
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("s4_pulse_held", 32'(stim_trigger), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("s4_pulse_last", 32'(stim_trigger), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("s4_idle_after", 32'(seq_state), 32'd0);

    // Arm drops in HOLDOFF.
    holdoff_len = 32'd3;
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < PULSE_CYC; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("s4_holdoff", 32'(seq_state), 32'd3);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("s4_holdoff_abort", 32'(seq_state), 32'd0);

    // Window length changed while tracking: old length applies.
    window_len = 32'd5;
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    window_len = 32'd2;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("s6_old_window", DAC_fsm_state_counter, 32'd3);
    check_eq("s6_still_track", 32'(seq_state), 32'd1);

    // Saturation of the trial counter.
    to_idle();
    window_len = 32'd1; holdoff_len = 32'd0;
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int s = 0; s < SAT + 3; s++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < PULSE_CYC; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    end
    check_eq("s6_saturated", 32'(stim_count), 32'(SAT));

    // Async reset in the middle of a stim pulse.
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("s5_in_stim", 32'(stim_trigger), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("s5_async_trig", 32'(stim_trigger), 32'd0);
    check_eq("s5_async_cnt", DAC_fsm_state_counter, 32'd0);
    check_eq("s5_async_count", 32'(stim_count), 32'd0);
    check_eq("s5_async_state", 32'(seq_state), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        window_len  = 32'($urandom_range(0, 5));
        holdoff_len = 32'($urandom_range(0, 3));
      end
      cycle(logic'($urandom_range(0, 19) != 0),
            logic'($urandom_range(0, 2) == 0),
            logic'($urandom_range(0, 9) != 0),
            logic'($urandom_range(0, 29) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
